// File: rtl/frame_column_loader.sv
// Configuration-stream loader for one fabric column: decodes header/data word
// pairs, drives FrameData and a one-hot FrameStrobe with setup/hold margins.
module frame_column_loader #(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int ColumnIndex     = 0,
    parameter int StrobeCycles    = 1
) (
    input  logic                       UserCLK,
    input  logic                       reset,
    input  logic [31:0]                cfg_word,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [MaxFramesPerCol-1:0] frames_loaded,
    output logic                       column_done,
    output logic                       cfg_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    localparam int             CW       = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(StrobeCycles - 1);
    localparam logic [7:0]     COL      = 8'(ColumnIndex);
    localparam logic [5:0]     NFRAMES  = 6'(MaxFramesPerCol);

    state_t                     r_state;
    state_t                     w_next;
    logic [7:0]                 r_col;
    logic [4:0]                 r_frame;
    logic                       r_clr;
    logic [CW-1:0]              r_cnt;
    logic [FrameBitsPerRow-1:0] r_data;
    logic [MaxFramesPerCol-1:0] r_strobe;
    logic [MaxFramesPerCol-1:0] r_loaded;
    logic                       r_done;
    logic                       r_error;

    logic                       w_ready;
    logic                       w_accept;
    logic                       w_hdr_ok;
    logic                       w_match;
    logic [MaxFramesPerCol-1:0] w_onehot;
    logic                       w_unused_bits;

    assign w_ready       = (r_state == S_IDLE) || (r_state == S_DATA);
    assign w_accept      = cfg_valid && w_ready;
    assign w_hdr_ok      = (cfg_word[31:24] == 8'hA5) && ({1'b0, cfg_word[4:0]} < NFRAMES);
    assign w_match       = (r_col == COL);
    assign w_onehot      = MaxFramesPerCol'(1) << r_frame;
    assign w_unused_bits = ^cfg_word[14:5];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept && w_hdr_ok) w_next = S_DATA;
            S_DATA:   if (w_accept) w_next = w_match ? S_SETUP : S_IDLE;
            S_SETUP:  w_next = S_STROBE;
            S_STROBE: if (r_cnt == '0) w_next = S_HOLD;
            S_HOLD:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge UserCLK) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge UserCLK) begin
        if (reset) begin
            r_col    <= '0;
            r_frame  <= '0;
            r_clr    <= 1'b0;
            r_cnt    <= '0;
            r_data   <= '0;
            r_strobe <= '0;
            r_loaded <= '0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_accept) begin
                if (w_hdr_ok) begin
                    r_col   <= cfg_word[23:16];
                    r_frame <= cfg_word[4:0];
                    r_clr   <= cfg_word[15];
                end else begin
                    r_error <= 1'b1;
                end
            end
            // A mismatched column leaves the data bus untouched.
            if (r_state == S_DATA && w_accept && w_match) begin
                r_data <= FrameBitsPerRow'(cfg_word);
                if (r_clr) r_loaded <= '0;
            end
            if (r_state == S_SETUP)
                r_cnt <= CNT_LOAD;
            else if (r_state == S_STROBE && r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
            r_strobe <= (w_next == S_STROBE) ? w_onehot : '0;
            if (r_state == S_STROBE && r_cnt == CNT_LOAD)
                r_loaded <= r_loaded | w_onehot;
            r_done <= &r_loaded;
        end
    end

    assign cfg_ready     = w_ready;
    assign FrameData     = r_data;
    assign FrameStrobe   = r_strobe;
    assign frames_loaded = r_loaded;
    assign column_done   = r_done;
    assign cfg_error     = r_error;

endmodule

// File: tb/tb_frame_column_loader.sv
// Directed bench for frame_column_loader: one instance with 1-cycle strobes,
// one with 3-cycle strobes, sharing the stimulus inputs.
module tb_frame_column_loader;

    logic        UserCLK = 1'b0;
    logic        reset;
    logic [31:0] cfg_word;
    logic        cfg_valid;

    logic        rdy1, cd1, er1;
    logic [31:0] fd1;
    logic [19:0] fs1, fl1;
    logic        rdy3, cd3, er3;
    logic [31:0] fd3;
    logic [19:0] fs3, fl3;

    int checks   = 0;
    int failures = 0;

    always #5 UserCLK = ~UserCLK;

    frame_column_loader #(.FrameBitsPerRow(32), .MaxFramesPerCol(20), .ColumnIndex(3), .StrobeCycles(1)) dut1 (
        .UserCLK(UserCLK), .reset(reset), .cfg_word(cfg_word), .cfg_valid(cfg_valid),
        .cfg_ready(rdy1), .FrameData(fd1), .FrameStrobe(fs1), .frames_loaded(fl1),
        .column_done(cd1), .cfg_error(er1)
    );

    frame_column_loader #(.FrameBitsPerRow(32), .MaxFramesPerCol(20), .ColumnIndex(3), .StrobeCycles(3)) dut3 (
        .UserCLK(UserCLK), .reset(reset), .cfg_word(cfg_word), .cfg_valid(cfg_valid),
        .cfg_ready(rdy3), .FrameData(fd3), .FrameStrobe(fs3), .frames_loaded(fl3),
        .column_done(cd3), .cfg_error(er3)
    );

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1; cfg_valid = 1'b0; cfg_word = '0;
        repeat (2) @(negedge UserCLK);
        reset = 1'b0;
    endtask

    // Presents a word with valid high; returns at the negedge after the accepting edge.
    task automatic send(input bit sel, input logic [31:0] w, input bit keep, output int waited);
        cfg_word = w; cfg_valid = 1'b1; waited = 0;
        while (!(sel ? rdy3 : rdy1) && waited < 50) begin
            @(negedge UserCLK);
            waited++;
        end
        if (waited >= 50) begin
            checks++; failures++;
            $display("FAIL send_timeout word=%h ready stayed low, required high within 50 cycles", w);
        end
        @(negedge UserCLK);
        if (!keep) cfg_valid = 1'b0;
    endtask

    task automatic pair1_check(input logic [31:0] hdr, input logic [31:0] dat,
                               input logic [19:0] exp_fs, input logic [19:0] exp_fl, input string nm);
        int w;
        send(1'b0, hdr, 1'b0, w);
        send(1'b0, dat, 1'b0, w);
        checks++;
        if (fd1 !== dat || fs1 !== 20'h0 || rdy1 !== 1'b0) begin
            failures++;
            $display("FAIL %s_setup fd=%h fs=%h rdy=%b, required fd=%h fs=00000 rdy=0", nm, fd1, fs1, rdy1, dat);
        end
        @(negedge UserCLK);
        checks++;
        if (fs1 !== exp_fs || rdy1 !== 1'b0 || fd1 !== dat) begin
            failures++;
            $display("FAIL %s_strobe fs=%h rdy=%b fd=%h, required fs=%h rdy=0 fd=%h", nm, fs1, rdy1, fd1, exp_fs, dat);
        end
        @(negedge UserCLK);
        checks++;
        if (fs1 !== 20'h0 || rdy1 !== 1'b0 || fl1 !== exp_fl) begin
            failures++;
            $display("FAIL %s_hold fs=%h rdy=%b fl=%h, required fs=00000 rdy=0 fl=%h", nm, fs1, rdy1, fl1, exp_fl);
        end
        @(negedge UserCLK);
        checks++;
        if (rdy1 !== 1'b1 || fs1 !== 20'h0) begin
            failures++;
            $display("FAIL %s_ready rdy=%b fs=%h, required rdy=1 fs=00000", nm, rdy1, fs1);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (rdy1 !== 1'b1 || fd1 !== 32'h0 || fs1 !== 20'h0) begin
            failures++;
            $display("FAIL reset_bus rdy=%b fd=%h fs=%h, required rdy=1 fd=0 fs=0", rdy1, fd1, fs1);
        end
        checks++;
        if (fl1 !== 20'h0 || cd1 !== 1'b0 || er1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_status fl=%h done=%b err=%b, required all 0", fl1, cd1, er1);
        end
        checks++;
        if (rdy3 !== 1'b1 || fs3 !== 20'h0 || fl3 !== 20'h0 || er3 !== 1'b0) begin
            failures++;
            $display("FAIL reset_dut3 rdy=%b fs=%h fl=%h err=%b, required 1/0/0/0", rdy3, fs3, fl3, er3);
        end
    endtask

    task automatic test_basic();
        pair1_check(32'hA5030005, 32'hDEADBEEF, 20'h00020, 20'h00020, "basic");
    endtask

    task automatic test_mismatch();
        int w;
        bit bad;
        send(1'b0, 32'hA5070002, 1'b0, w);
        send(1'b0, 32'h12345678, 1'b0, w);
        checks++;
        if (rdy1 !== 1'b1 || fd1 !== 32'hDEADBEEF || fs1 !== 20'h0) begin
            failures++;
            $display("FAIL mismatch_d1 rdy=%b fd=%h fs=%h, required rdy=1 fd=deadbeef fs=0", rdy1, fd1, fs1);
        end
        send(1'b0, 32'hA5070004, 1'b0, w);
        checks++;
        if (w !== 0) begin
            failures++;
            $display("FAIL mismatch_next_hdr waited=%0d cycles, required 0", w);
        end
        send(1'b0, 32'h0BADF00D, 1'b0, w);
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (fs1 !== 20'h0 || rdy1 !== 1'b1) bad = 1'b1;
            @(negedge UserCLK);
        end
        checks++;
        if (bad || fd1 !== 32'hDEADBEEF || fl1 !== 20'h00020) begin
            failures++;
            $display("FAIL mismatch_quiet strobe_or_ready_bad=%b fd=%h fl=%h, required 0 deadbeef 00020", bad, fd1, fl1);
        end
    endtask

    task automatic test_errors();
        int w;
        send(1'b0, 32'h5A030001, 1'b0, w);
        checks++;
        if (er1 !== 1'b1 || rdy1 !== 1'b1) begin
            failures++;
            $display("FAIL err_sync err=%b rdy=%b, required err=1 rdy=1", er1, rdy1);
        end
        send(1'b0, 32'hA5030014, 1'b0, w);
        checks++;
        if (er1 !== 1'b1 || fs1 !== 20'h0 || rdy1 !== 1'b1) begin
            failures++;
            $display("FAIL err_frame20 err=%b fs=%h rdy=%b, required 1 00000 1", er1, fs1, rdy1);
        end
        pair1_check(32'hA5030013, 32'hCAFEF00D, 20'h80000, 20'h80020, "frame19");
        checks++;
        if (er1 !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky err=%b, required 1", er1);
        end
    endtask

    task automatic test_back_to_back();
        int w, cnt;
        bit bad;
        logic [19:0] exp;
        do_reset();
        for (int f = 0; f < 20; f++) begin
            exp = 20'h1 << f;
            send(1'b1, 32'hA5030000 | f, 1'b1, w);
            if (f > 0) begin
                checks++;
                if (w !== 0) begin
                    failures++;
                    $display("FAIL b2b_period frame=%0d header waited=%0d, required 0", f, w);
                end
            end
            send(1'b1, 32'h00000100 + f, 1'b1, w);
            cnt = 0; bad = 1'b0;
            for (int k = 1; k <= 6; k++) begin
                if (k > 1) @(negedge UserCLK);
                if (fs3 !== 20'h0) begin
                    cnt++;
                    if (fs3 !== exp) bad = 1'b1;
                end
                if (f == 19 && k == 3) begin
                    checks++;
                    if (fl3 !== 20'hFFFFF || cd3 !== 1'b0) begin
                        failures++;
                        $display("FAIL b2b_last_bit fl=%h done=%b, required fffff 0", fl3, cd3);
                    end
                end
                if (f == 19 && k == 4) begin
                    checks++;
                    if (cd3 !== 1'b1) begin
                        failures++;
                        $display("FAIL b2b_done done=%b, required 1", cd3);
                    end
                end
                if (k == 6 && f == 19) cfg_valid = 1'b0;
            end
            checks++;
            if (cnt !== 3 || bad || rdy3 !== 1'b1) begin
                failures++;
                $display("FAIL b2b_strobe frame=%0d width=%0d wrong_bits=%b rdy=%b, required width 3 bits %h rdy 1", f, cnt, bad, rdy3, exp);
            end
        end
    endtask

    task automatic test_clear();
        int w;
        send(1'b1, 32'hA5038000, 1'b0, w);
        send(1'b1, 32'h11111111, 1'b0, w);
        checks++;
        if (fl3 !== 20'h0 || fd3 !== 32'h11111111) begin
            failures++;
            $display("FAIL clear_d1 fl=%h fd=%h, required 00000 11111111", fl3, fd3);
        end
        @(negedge UserCLK);
        checks++;
        if (fs3 !== 20'h00001) begin
            failures++;
            $display("FAIL clear_strobe fs=%h, required 00001", fs3);
        end
        @(negedge UserCLK);
        checks++;
        if (fl3 !== 20'h00001 || cd3 !== 1'b0) begin
            failures++;
            $display("FAIL clear_result fl=%h done=%b, required 00001 0", fl3, cd3);
        end
        repeat (4) @(negedge UserCLK);
    endtask

    task automatic test_reset_mid();
        int w;
        do_reset();
        send(1'b0, 32'hA5030005, 1'b0, w);
        send(1'b0, 32'hAAAA5555, 1'b0, w);
        @(negedge UserCLK);
        checks++;
        if (fs1 !== 20'h00020) begin
            failures++;
            $display("FAIL rstmid_prestrobe fs=%h, required 00020", fs1);
        end
        reset = 1'b1;
        @(negedge UserCLK);
        checks++;
        if (fs1 !== 20'h0 || fd1 !== 32'h0 || fl1 !== 20'h0 || rdy1 !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_abort fs=%h fd=%h fl=%h rdy=%b, required 0 0 0 1", fs1, fd1, fl1, rdy1);
        end
        reset = 1'b0;
        @(negedge UserCLK);
        checks++;
        if (fs1 !== 20'h0 || rdy1 !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_quiet fs=%h rdy=%b, required 00000 1", fs1, rdy1);
        end
        pair1_check(32'hA5030005, 32'hDEADBEEF, 20'h00020, 20'h00020, "after_reset");
    endtask

    task automatic send_rand(input logic [31:0] w);
        bit v, ok;
        int n;
        n = 0; ok = 1'b0;
        while (!ok && n < 100) begin
            v = 1'($urandom_range(0, 1));
            cfg_valid = v;
            cfg_word  = v ? w : $urandom;
            ok = v && rdy1;
            @(negedge UserCLK);
            n++;
        end
        cfg_valid = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL rand_timeout word=%h not accepted within 100 cycles", w);
        end
    endtask

    task automatic test_random_valid();
        logic [4:0]  frm [3] = '{5'd1, 5'd10, 5'd0};
        logic [31:0] dat [3] = '{32'h01020304, 32'hF0E1D2C3, 32'h5A5A0F0F};
        logic [19:0] fl_exp  = 20'h00020;
        logic [19:0] fs_exp;
        for (int p = 0; p < 3; p++) begin
            fs_exp = 20'h1 << frm[p];
            fl_exp = fl_exp | fs_exp;
            send_rand(32'hA5030000 | 32'(frm[p]));
            repeat ($urandom_range(0, 3)) @(negedge UserCLK);
            send_rand(dat[p]);
            checks++;
            if (fd1 !== dat[p] || fs1 !== 20'h0) begin
                failures++;
                $display("FAIL rand_setup pair=%0d fd=%h fs=%h, required fd=%h fs=00000", p, fd1, fs1, dat[p]);
            end
            @(negedge UserCLK);
            checks++;
            if (fs1 !== fs_exp) begin
                failures++;
                $display("FAIL rand_strobe pair=%0d fs=%h, required %h", p, fs1, fs_exp);
            end
            @(negedge UserCLK);
            checks++;
            if (fl1 !== fl_exp || fs1 !== 20'h0) begin
                failures++;
                $display("FAIL rand_loaded pair=%0d fl=%h fs=%h, required fl=%h fs=00000", p, fl1, fs1, fl_exp);
            end
            @(negedge UserCLK);
        end
        checks++;
        if (er1 !== 1'b0 || rdy1 !== 1'b1) begin
            failures++;
            $display("FAIL rand_no_stray err=%b rdy=%b, required err=0 rdy=1", er1, rdy1);
        end
    endtask

    initial begin
        reset = 1'b1; cfg_valid = 1'b0; cfg_word = '0;
        test_reset();
        test_basic();
        test_mismatch();
        test_errors();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        test_random_valid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
